// File: rtl/bill_accum.sv
// ============================================================================
//  Module   : bill_accum
//  Purpose  : Debounces per-frame item labels, commits each placed item once
//             and accumulates a 4-digit BCD bill total plus an item count.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef POSITION_WIDTH
`define POSITION_WIDTH 11
`endif
`ifndef PIC_X2
`define PIC_X2 639
`endif
`ifndef PIC_Y2
`define PIC_Y2 479
`endif

module bill_accum #(
    parameter int P_W            = `POSITION_WIDTH,
    parameter int STABLE_FRAMES  = 8,
    parameter int RELEASE_FRAMES = 4
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic [P_W-1:0] cnt_x_5,
    input  logic [P_W-1:0] cnt_y_5,
    input  logic           inpic_5,
    input  logic [63:0]    i_label,
    input  logic           bill_clr,
    output logic [15:0]    o_total_bcd,
    output logic [7:0]     o_item_cnt,
    output logic [63:0]    o_last_label,
    output logic           o_commit,
    output logic           o_busy
);

    localparam logic [P_W-1:0] c_PIC_X2  = P_W'(`PIC_X2);
    localparam logic [P_W-1:0] c_PIC_Y2  = P_W'(`PIC_Y2);
    localparam logic [3:0]     c_STABLE  = 4'(STABLE_FRAMES);
    localparam logic [3:0]     c_RELEASE = 4'(RELEASE_FRAMES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CAND      = 2'd1,
        ADD       = 2'd2,
        COMMITTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        fe_q, fe_d;
    logic [3:0]  stable_q, stable_d;
    logic [3:0]  release_q, release_d;
    logic [63:0] cand_q, cand_d;
    logic [1:0]  step_q, step_d;
    logic        carry_q, carry_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] total_q, total_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] last_q, last_d;
    logic        commit_q, commit_d;

    logic        w_valid;
    logic        w_go_add;
    logic [3:0]  w_cur_digit;
    logic [3:0]  w_addend;
    logic [4:0]  w_sum;
    logic [3:0]  w_digit;
    logic        w_cout;

    function automatic logic is_digit(input logic [7:0] ch);
        return (ch >= 8'h30) && (ch <= 8'h39);
    endfunction

    // Valid label shape: byte3 '+', byte1 '.', byte2/byte0 decimal digits.
    assign w_valid = (i_label[31:24] == 8'h2B) && (i_label[15:8] == 8'h2E) &&
                     is_digit(i_label[23:16]) && is_digit(i_label[7:0]);

    assign fe_d = inpic_5 && (cnt_x_5 == c_PIC_X2) && (cnt_y_5 == c_PIC_Y2);

    // One BCD digit per ADD cycle; ASCII digit low nibble equals its value.
    always_comb begin
        w_cur_digit = shadow_q[{step_q, 2'b00} +: 4];
        w_addend    = (step_q == 2'd0) ? cand_q[3:0] :
                      (step_q == 2'd1) ? cand_q[19:16] : 4'd0;
        w_sum       = {1'b0, w_cur_digit} + {1'b0, w_addend} + {4'd0, carry_q};
        w_cout      = (w_sum > 5'd9);
        w_digit     = w_cout ? 4'(w_sum - 5'd10) : w_sum[3:0];
    end

    always_comb begin
        state_d   = state_q;
        stable_d  = stable_q;
        release_d = release_q;
        cand_d    = cand_q;
        step_d    = step_q;
        carry_d   = carry_q;
        shadow_d  = shadow_q;
        total_d   = total_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        commit_d  = 1'b0;
        w_go_add  = 1'b0;

        if (state_q == ADD) begin
            shadow_d[{step_q, 2'b00} +: 4] = w_digit;
            carry_d = w_cout;
            step_d  = step_q + 2'd1;
            if (step_q == 2'd3) begin
                total_d   = w_cout ? 16'h9999 : {w_digit, shadow_q[11:0]};
                cnt_d     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                last_d    = cand_q;
                commit_d  = 1'b1;
                stable_d  = 4'd0;
                release_d = 4'd0;
                state_d   = COMMITTED;
            end
        end else if (fe_q) begin
            case (state_q)
                IDLE: begin
                    if (w_valid) begin
                        cand_d   = i_label;
                        stable_d = 4'd1;
                        state_d  = CAND;
                        w_go_add = (c_STABLE == 4'd1);
                    end
                end
                CAND: begin
                    if (!w_valid) begin
                        stable_d = 4'd0;
                        state_d  = IDLE;
                    end else if (i_label == cand_q) begin
                        stable_d = stable_q + 4'd1;
                        w_go_add = (stable_q + 4'd1 >= c_STABLE);
                    end else begin
                        cand_d   = i_label;
                        stable_d = 4'd1;
                        w_go_add = (c_STABLE == 4'd1);
                    end
                end
                COMMITTED: begin
                    if (w_valid && (i_label == last_q)) begin
                        release_d = 4'd0;
                    end else if (w_valid) begin
                        cand_d    = i_label;
                        stable_d  = 4'd1;
                        release_d = 4'd0;
                        state_d   = CAND;
                        w_go_add  = (c_STABLE == 4'd1);
                    end else if (release_q + 4'd1 >= c_RELEASE) begin
                        release_d = 4'd0;
                        state_d   = IDLE;
                    end else begin
                        release_d = release_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (w_go_add) begin
                state_d  = ADD;
                shadow_d = total_q;
                carry_d  = 1'b0;
                step_d   = 2'd0;
            end
        end

        // Clear has priority over any sample or ADD completion.
        if (bill_clr) begin
            state_d   = IDLE;
            stable_d  = 4'd0;
            release_d = 4'd0;
            step_d    = 2'd0;
            carry_d   = 1'b0;
            shadow_d  = 16'd0;
            total_d   = 16'd0;
            cnt_d     = 8'd0;
            last_d    = 64'd0;
            commit_d  = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            fe_q      <= 1'b0;
            stable_q  <= 4'd0;
            release_q <= 4'd0;
            cand_q    <= 64'd0;
            step_q    <= 2'd0;
            carry_q   <= 1'b0;
            shadow_q  <= 16'd0;
            total_q   <= 16'd0;
            cnt_q     <= 8'd0;
            last_q    <= 64'd0;
            commit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            fe_q      <= fe_d;
            stable_q  <= stable_d;
            release_q <= release_d;
            cand_q    <= cand_d;
            step_q    <= step_d;
            carry_q   <= carry_d;
            shadow_q  <= shadow_d;
            total_q   <= total_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            commit_q  <= commit_d;
        end
    end

    assign o_total_bcd  = total_q;
    assign o_item_cnt   = cnt_q;
    assign o_last_label = last_q;
    assign o_commit     = commit_q;
    assign o_busy       = (state_q == ADD);

endmodule

`default_nettype wire
